// File: rtl/mem_stage_ctrl_pkg.sv
// Shared pipeline definitions for the MEM-stage access controller.
package mem_stage_ctrl_pkg;

    // MEM-stage FSM: IDLE accepts a new EX/MEM slot, WAIT holds for dmem_ack.
    typedef enum logic {
        MS_IDLE = 1'b0,
        MS_WAIT = 1'b1
    } ms_state_t;

    // Default bound on WAIT cycles without an ack before the access is aborted.
    localparam int MS_ACK_TIMEOUT = 255;

    // Width of the WAIT-cycle counter; covers any ACK_TIMEOUT up to 256.
    localparam int MS_CNT_W = 8;

endpackage : mem_stage_ctrl_pkg

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory access controller and MEM/WB pipeline register.
// Issues word loads/stores over a req/ack handshake, freezes upstream with
// a combinational stall while an access is outstanding, and aborts with an
// error after ACK_TIMEOUT WAIT cycles without an ack.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int ACK_TIMEOUT = MS_ACK_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_mem_ren,
    input  logic        in_mem_wen,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_alu_res,
    input  logic [31:0] in_data_rt,
    input  logic [4:0]  in_regw_addr,
    input  logic        in_wb_wen,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_wb_data,
    output logic [4:0]  out_regw_addr,
    output logic        out_wb_wen,
    output logic        out_err
);

    // Counter value reached in the ACK_TIMEOUT-th WAIT cycle.
    localparam logic [MS_CNT_W-1:0] TIMEOUT_LAST = MS_CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [MS_CNT_W-1:0] CNT_MAX      = '1;

    ms_state_t           state;
    ms_state_t           state_next;
    logic [MS_CNT_W-1:0] ack_cnt;
    logic                mem_op;
    logic                mis;
    logic                timeout_hit;
    logic                start_access;

    // Decode the EX/MEM slot, detect timeout, drive stall and pick next state.
    always_comb begin
        // NOTE: every signal gets a default at the top so no path through this
        // block leaves a value unassigned, which would infer a latch.
        state_next   = state;
        mem_op       = in_valid & (in_mem_ren | in_mem_wen);
        mis          = (in_alu_res[1:0] != 2'b00);
        start_access = 1'b0;
        timeout_hit  = 1'b0;
        stall        = 1'b0;

        case (state)
            MS_IDLE: begin
                start_access = mem_op & ~mis;
                stall        = start_access;
                if (start_access) begin
                    state_next = MS_WAIT;
                end
            end
            MS_WAIT: begin
                timeout_hit = ~dmem_ack & (ack_cnt == TIMEOUT_LAST);
                stall       = ~dmem_ack & ~timeout_hit;
                if (dmem_ack || timeout_hit) begin
                    state_next = MS_IDLE;
                end
            end
            default: begin
                state_next = MS_IDLE;
            end
        endcase
    end

    // FSM state, WAIT counter, memory request registers and MEM/WB register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state         <= MS_IDLE;
            ack_cnt       <= '0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            out_valid     <= 1'b0;
            out_pc        <= '0;
            out_wb_data   <= '0;
            out_regw_addr <= '0;
            out_wb_wen    <= 1'b0;
            out_err       <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                MS_IDLE: begin
                    if (start_access) begin
                        // Launch the access; store wins when both ren and wen are set.
                        dmem_req   <= 1'b1;
                        dmem_we    <= in_mem_wen;
                        dmem_addr  <= in_alu_res;
                        dmem_wdata <= in_data_rt;
                        ack_cnt    <= '0;
                        out_valid  <= 1'b0;
                        out_wb_wen <= 1'b0;
                        out_err    <= 1'b0;
                    end else if (mem_op) begin
                        // Misaligned access: retire immediately as an exception.
                        out_valid     <= 1'b1;
                        out_err       <= 1'b1;
                        out_wb_wen    <= 1'b0;
                        out_pc        <= in_pc;
                        out_regw_addr <= in_regw_addr;
                        out_wb_data   <= in_alu_res;
                    end else begin
                        out_valid     <= in_valid;
                        out_err       <= 1'b0;
                        out_wb_wen    <= in_wb_wen & in_valid;
                        out_pc        <= in_pc;
                        out_regw_addr <= in_regw_addr;
                        out_wb_data   <= in_alu_res;
                    end
                end
                MS_WAIT: begin
                    if (dmem_ack) begin
                        dmem_req      <= 1'b0;
                        out_valid     <= 1'b1;
                        out_err       <= 1'b0;
                        out_wb_wen    <= in_wb_wen;
                        out_pc        <= in_pc;
                        out_regw_addr <= in_regw_addr;
                        out_wb_data   <= dmem_we ? in_alu_res : dmem_rdata;
                    end else if (timeout_hit) begin
                        dmem_req      <= 1'b0;
                        out_valid     <= 1'b1;
                        out_err       <= 1'b1;
                        out_wb_wen    <= 1'b0;
                        out_pc        <= in_pc;
                        out_regw_addr <= in_regw_addr;
                        out_wb_data   <= in_alu_res;
                    end else begin
                        if (ack_cnt != CNT_MAX) begin
                            ack_cnt <= ack_cnt + 1'b1;
                        end
                        out_valid  <= 1'b0;
                        out_wb_wen <= 1'b0;
                        out_err    <= 1'b0;
                    end
                end
                default: begin
                    dmem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule : mem_stage_ctrl

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: a driver issues EX/MEM slots and
// pushes the expected MEM/WB result; a memory responder acks after a chosen
// delay; a monitor pops and compares whenever out_valid is seen.
module tb_mem_stage_ctrl;

    localparam int T     = 4;   // ACK_TIMEOUT used for the DUT
    localparam int NEVER = -1;  // memory delay meaning "never ack"

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic [4:0]  regw;
        logic        wen;
        logic        err;
        logic        chk_data;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_mem_ren, in_mem_wen;
    logic [31:0] in_pc, in_alu_res, in_data_rt;
    logic [4:0]  in_regw_addr;
    logic        in_wb_wen;
    logic        stall;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        out_valid;
    logic [31:0] out_pc, out_wb_data;
    logic [4:0]  out_regw_addr;
    logic        out_wb_wen, out_err;

    int          errors = 0;
    int          checks = 0;
    res_t        sb[$];

    // Memory model controls, written by the driver.
    int          mem_delay = NEVER;
    logic [31:0] mem_rdata_val = '0;
    logic [31:0] exp_addr = '0;
    logic        exp_we = 1'b0;
    logic [31:0] exp_wdata = '0;
    int          req_count = 0;
    bit          late_ack_req = 1'b0;

    mem_stage_ctrl #(.ACK_TIMEOUT(T)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_mem_ren   (in_mem_ren),
        .in_mem_wen   (in_mem_wen),
        .in_pc        (in_pc),
        .in_alu_res   (in_alu_res),
        .in_data_rt   (in_data_rt),
        .in_regw_addr (in_regw_addr),
        .in_wb_wen    (in_wb_wen),
        .stall        (stall),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .out_valid    (out_valid),
        .out_pc       (out_pc),
        .out_wb_data  (out_wb_data),
        .out_regw_addr(out_regw_addr),
        .out_wb_wen   (out_wb_wen),
        .out_err      (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        in_valid     = 1'b0;
        in_mem_ren   = 1'b0;
        in_mem_wen   = 1'b0;
        in_pc        = '0;
        in_alu_res   = '0;
        in_data_rt   = '0;
        in_regw_addr = '0;
        in_wb_wen    = 1'b0;
    endtask

    // Called just after a rising edge; returns just after the rising edge
    // following the cycle in which the slot was accepted (stall low).
    task automatic issue(input logic v, input logic ren, input logic wen,
                         input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] rt, input logic [4:0] rw,
                         input logic wbw, input int d, input logic [31:0] rd,
                         input string tag);
        bit   mem_op;
        bit   mis;
        int   exp_stall;
        int   exp_req;
        int   n_stall;
        res_t r;
        mem_op    = v && (ren || wen);
        mis       = (alu[1:0] != 2'b00);
        exp_stall = 0;
        exp_req   = 0;
        n_stall   = 0;
        r.pc = pc; r.regw = rw; r.data = alu; r.wen = 1'b0; r.err = 1'b0; r.chk_data = 1'b1;
        if (!mem_op) begin
            r.wen = wbw;
            if (v) sb.push_back(r);
        end else if (mis) begin
            r.err = 1'b1; r.chk_data = 1'b0;
            sb.push_back(r);
        end else if (d >= 0 && d < T) begin
            exp_stall = 1 + d;
            exp_req   = d + 1;
            r.wen     = wbw;
            r.data    = wen ? alu : rd;
            sb.push_back(r);
        end else begin
            exp_stall = T;
            exp_req   = T;
            r.err = 1'b1; r.chk_data = 1'b0;
            sb.push_back(r);
        end

        mem_delay     = d;
        mem_rdata_val = rd;
        exp_addr      = alu;
        exp_we        = wen;
        exp_wdata     = rt;

        in_valid = v; in_mem_ren = ren; in_mem_wen = wen; in_pc = pc;
        in_alu_res = alu; in_data_rt = rt; in_regw_addr = rw; in_wb_wen = wbw;

        forever begin
            @(negedge clk);
            if (!stall) break;
            n_stall++;
            if (n_stall > 300) begin
                checks++; errors++;
                $display("FAIL %s_stall_budget: stall still high after %0d cycles", tag, n_stall);
                break;
            end
            @(posedge clk); #1;
        end
        check({tag, "_stall_cycles"}, n_stall, exp_stall);
        check({tag, "_req_cycles"}, req_count, exp_req);
        req_count = 0;
        @(posedge clk); #1;
    endtask

    // Variable-latency memory: acks in the d-th cycle after req rises (d=0: same cycle).
    initial begin
        int age;
        age        = -1;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            dmem_ack   = 1'b0;
            dmem_rdata = 32'hx;
            if (late_ack_req) begin
                dmem_ack     = 1'b1;
                dmem_rdata   = 32'hBAD0_BAD0;
                late_ack_req = 1'b0;
            end else if (dmem_req && !rst) begin
                age++;
                req_count++;
                check("dmem_addr", dmem_addr, exp_addr);
                check("dmem_we", {31'b0, dmem_we}, {31'b0, exp_we});
                if (exp_we) check("dmem_wdata", dmem_wdata, exp_wdata);
                if (mem_delay >= 0 && age == mem_delay) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = mem_rdata_val;
                end
            end else begin
                age = -1;
            end
        end
    end

    // Monitor: every MEM/WB valid must match the oldest expected result.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result: out_valid with pc %h, nothing expected", out_pc);
                end else begin
                    e = sb.pop_front();
                    check("out_pc", out_pc, e.pc);
                    check("out_regw_addr", {27'b0, out_regw_addr}, {27'b0, e.regw});
                    check("out_wb_wen", {31'b0, out_wb_wen}, {31'b0, e.wen});
                    check("out_err", {31'b0, out_err}, {31'b0, e.err});
                    if (e.chk_data) check("out_wb_data", out_wb_data, e.data);
                end
            end
        end
    end

    // Global watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          kind;
        int          d;
        logic [31:0] a;
        drive_idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {24'b0, dmem_req, dmem_we, out_valid, out_wb_wen, out_err, 3'b0},
              32'h0);
        check("reset_stall", {31'b0, stall}, 32'h0);
        check("reset_out_pc", out_pc, 32'h0);
        check("reset_wb_data", out_wb_data, 32'h0);
        check("reset_dmem_addr", dmem_addr, 32'h0);
        rst = 1'b0;

        // Directed cases.
        issue(1, 0, 0, 32'h0000_1000, 32'h0000_1234, 32'h0, 5'd5, 1, NEVER, 32'h0, "alu");
        issue(1, 1, 0, 32'h0000_1004, 32'h0000_0040, 32'h0, 5'd7, 1, 3, 32'hDEAD_BEEF, "load");
        issue(1, 0, 1, 32'h0000_1008, 32'h0000_0080, 32'hA5A5_A5A5, 5'd0, 0, 1, 32'h0, "store");
        issue(1, 1, 0, 32'h0000_100C, 32'h0000_0041, 32'h0, 5'd9, 1, 0, 32'h0, "mis_load");
        issue(1, 1, 0, 32'h0000_1010, 32'h0000_0100, 32'h0, 5'd3, 1, NEVER, 32'h0, "timeout");

        // Late ack in IDLE must change nothing.
        drive_idle();
        late_ack_req = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("late_ack_req_low", {31'b0, dmem_req}, 32'h0);
        check("late_ack_no_stall", {31'b0, stall}, 32'h0);
        @(posedge clk); #1;

        // Reset two cycles into WAIT.
        mem_delay = NEVER; exp_addr = 32'h0000_0200; exp_we = 1'b0;
        in_valid = 1; in_mem_ren = 1; in_mem_wen = 0; in_pc = 32'h0000_2000;
        in_alu_res = 32'h0000_0200; in_regw_addr = 5'd4; in_wb_wen = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        drive_idle();
        check("rst_wait_req", {31'b0, dmem_req}, 32'h0);
        check("rst_wait_flags", {29'b0, out_valid, out_wb_wen, out_err}, 32'h0);
        check("rst_wait_pc", out_pc, 32'h0);
        rst = 1'b0;
        req_count = 0;
        @(posedge clk); #1;
        issue(1, 0, 0, 32'h0000_3000, 32'h0000_5678, 32'h0, 5'd12, 1, NEVER, 32'h0, "alu_after_rst");

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 9);
            d    = $urandom_range(0, 4);
            if (d == 4) d = NEVER;
            a = $urandom;
            if (kind <= 5 && kind >= 2) a[1:0] = 2'b00;
            case (kind)
                0: issue(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, a, $urandom,
                         5'($urandom), 1, d, $urandom, "rnd_bubble");
                1: issue(1, 0, 0, $urandom, a, $urandom, 5'($urandom), $urandom_range(0, 1),
                         d, $urandom, "rnd_alu");
                2, 3: issue(1, 1, 0, $urandom, a, $urandom, 5'($urandom), 1, d, $urandom, "rnd_load");
                4: issue(1, 0, 1, $urandom, a, $urandom, 5'($urandom), 0, d, $urandom, "rnd_store");
                5: issue(1, 1, 1, $urandom, a, $urandom, 5'($urandom), $urandom_range(0, 1),
                         d, $urandom, "rnd_both");
                default: begin
                    if (a[1:0] == 2'b00) a[0] = 1'b1;
                    issue(1, $urandom_range(0, 1), 1'b1, $urandom, a, $urandom, 5'($urandom),
                          1, d, $urandom, "rnd_mis");
                end
            endcase
        end

        drive_idle();
        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mem_stage_ctrl
